// File: rtl/kalman_pkg.sv
// Shared types and helpers for the Kalman filter datapath stages.
// Element-wise stages reuse the stage FSM encoding and the saturating add/sub.
package kalman_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } stageState_t;

   // Widest element format the helper handles; element widths must stay below this.
   localparam int SAT_MAX_W = 64;

   typedef struct packed {
      logic signed [SAT_MAX_W-1:0] y;
      logic                        sat;
   } satResult_t;

   // a and b are sign-extended w-bit values; one guard bit holds the carry before clamping.
   function automatic satResult_t satAddSub(
      input logic signed [SAT_MAX_W-1:0] a,
      input logic signed [SAT_MAX_W-1:0] b,
      input logic                        sub,
      input int                          w
   );
      logic signed [SAT_MAX_W:0] full;
      logic signed [SAT_MAX_W:0] maxV;
      logic signed [SAT_MAX_W:0] minV;
      satResult_t                r;
      full = sub ? ((SAT_MAX_W+1)'(a) - (SAT_MAX_W+1)'(b))
                 : ((SAT_MAX_W+1)'(a) + (SAT_MAX_W+1)'(b));
      maxV = ((SAT_MAX_W+1)'(1) << (w - 1)) - (SAT_MAX_W+1)'(1);
      minV = -((SAT_MAX_W+1)'(1) << (w - 1));
      r.sat = 1'b1;
      if (full > maxV) begin
         r.y = maxV[SAT_MAX_W-1:0];
      end else if (full < minV) begin
         r.y = minV[SAT_MAX_W-1:0];
      end else begin
         r.y   = full[SAT_MAX_W-1:0];
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/sat_add_sub.sv
// Single-element saturating adder/subtractor for WIDTH-bit signed fixed point.
// WIDTH must be below kalman_pkg::SAT_MAX_W.
module sat_add_sub
   import kalman_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   input  logic                    sub,
   output logic signed [WIDTH-1:0] y,
   output logic                    sat
);

   satResult_t res;
   logic       extUnused;

   always_comb begin
      res = satAddSub(SAT_MAX_W'(a), SAT_MAX_W'(b), sub, WIDTH);
      y   = res.y[WIDTH-1:0];
      sat = res.sat;
   end

   // Above WIDTH the clamped result is pure sign extension.
   assign extUnused = ^res.y[SAT_MAX_W-1:WIDTH];

endmodule

// File: rtl/matrix_add_sat.sv
// Element-wise saturating matrix add/subtract (Res = A +/- B), one element per cycle.
// Operands are snapshotted on start so upstream may change them while the stage runs.
module matrix_add_sat
   import kalman_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int nos       = 4,
   parameter int intDigits = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    startAdd,
   input  logic                    subSel,
   input  logic signed [WIDTH-1:0] A   [nos][nos],
   input  logic signed [WIDTH-1:0] B   [nos][nos],
   output logic signed [WIDTH-1:0] Res [nos][nos],
   output logic                    endAdd,
   output logic                    ovf
);

   localparam int RC_W = (nos > 1) ? $clog2(nos) : 1;
   localparam logic [RC_W-1:0] LAST_RC = RC_W'(nos - 1);

   // Handshake: startAdd is a request taken only in IDLE; endAdd is a one-cycle
   // strobe, and Res/ovf stay valid from it until the next endAdd.
   stageState_t             state;
   logic signed [WIDTH-1:0] opA  [nos][nos];
   logic signed [WIDTH-1:0] opB  [nos][nos];
   logic signed [WIDTH-1:0] work [nos][nos];
   logic                    opSub;
   logic [RC_W-1:0]         row;
   logic [RC_W-1:0]         col;
   logic                    sticky;
   logic signed [WIDTH-1:0] elemY;
   logic                    elemSat;
   logic [31:0]             fmtUnused;

   // The binary point does not move under add/sub, so intDigits only labels the format.
   assign fmtUnused = 32'(intDigits);

   sat_add_sub #(.WIDTH(WIDTH)) u_satAddSub (
      .a   (opA[row][col]),
      .b   (opB[row][col]),
      .sub (opSub),
      .y   (elemY),
      .sat (elemSat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         opSub  <= 1'b0;
         row    <= '0;
         col    <= '0;
         sticky <= 1'b0;
         endAdd <= 1'b0;
         ovf    <= 1'b0;
         for (int r = 0; r < nos; r++) begin
            for (int c = 0; c < nos; c++) begin
               opA[r][c]  <= '0;
               opB[r][c]  <= '0;
               work[r][c] <= '0;
               Res[r][c]  <= '0;
            end
         end
      end else begin
         endAdd <= 1'b0;
         case (state)
            IDLE: begin
               if (startAdd) state <= LOAD;
            end
            LOAD: begin
               opA    <= A;
               opB    <= B;
               opSub  <= subSel;
               row    <= '0;
               col    <= '0;
               sticky <= 1'b0;
               state  <= RUN;
            end
            RUN: begin
               work[row][col] <= elemY;
               sticky         <= sticky | elemSat;
               // Row-major walk: column fastest, DONE after the bottom-right element.
               if (col == LAST_RC) begin
                  col <= '0;
                  if (row == LAST_RC) begin
                     row   <= '0;
                     state <= DONE;
                  end else begin
                     row <= row + 1'b1;
                  end
               end else begin
                  col <= col + 1'b1;
               end
            end
            DONE: begin
               Res    <= work;
               ovf    <= sticky;
               endAdd <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_add_sat.sv
// Self-checking bench for matrix_add_sat against a plain-arithmetic matrix model.
module tb_matrix_add_sat;

   localparam int W    = 16;
   localparam int N    = 4;
   localparam int LAT  = N*N + 2;
   localparam int MAXV = 2**(W-1) - 1;
   localparam int MINV = -(2**(W-1));

   logic                clk = 1'b0;
   logic                rst_n;
   logic                startAdd;
   logic                subSel;
   logic signed [W-1:0] A   [N][N];
   logic signed [W-1:0] B   [N][N];
   logic signed [W-1:0] Res [N][N];
   logic                endAdd;
   logic                ovf;

   logic [W-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   matrix_add_sat #(.WIDTH(W), .nos(N), .intDigits(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .startAdd (startAdd),
      .subSel   (subSel),
      .A        (A),
      .B        (B),
      .Res      (Res),
      .endAdd   (endAdd),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic fill_const(input logic [W-1:0] av, input logic [W-1:0] bv);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            A[r][c] = av;
            B[r][c] = bv;
         end
   endtask

   task automatic fill_random();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            A[r][c] = W'($urandom_range(0, 65535));
            B[r][c] = W'($urandom_range(0, 65535));
         end
   endtask

   // Reference: each element is the true integer sum/difference clamped to the signed range.
   task automatic model_op(input logic sub, output logic expOvf);
      int a, b, s;
      expOvf = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a = A[r][c];
            b = B[r][c];
            s = sub ? a - b : a + b;
            if (s > MAXV) begin
               s = MAXV;
               expOvf = 1'b1;
            end else if (s < MINV) begin
               s = MINV;
               expOvf = 1'b1;
            end
            exp_q.push_back(s[W-1:0]);
         end
   endtask

   task automatic push_zeros();
      for (int i = 0; i < N*N; i++) exp_q.push_back('0);
   endtask

   function automatic int res_mismatches();
      int bad = 0;
      logic [W-1:0] e;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            if (exp_q.size() == 0) begin
               bad++;
            end else begin
               e = exp_q.pop_front();
               if (Res[r][c] !== e) begin
                  bad++;
                  $display("  elem[%0d][%0d] got %h want %h", r, c, Res[r][c], e);
               end
            end
         end
      return bad;
   endfunction

   task automatic do_reset();
      rst_n    = 1'b0;
      startAdd = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Pulses startAdd for edge 0, then counts edges until endAdd; also notes early Res motion.
   task automatic start_and_wait(output int lat, output logic endAfter, output logic early);
      logic signed [W-1:0] snap [N][N];
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) snap[r][c] = Res[r][c];
      lat = -1;
      endAfter = 1'b0;
      early = 1'b0;
      startAdd = 1'b1;
      @(posedge clk); #1;
      startAdd = 1'b0;
      for (int k = 1; k <= LAT + 20 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (endAdd === 1'b1) lat = k;
         else
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++)
                  if (Res[r][c] !== snap[r][c]) early = 1'b1;
      end
      if (lat >= 0) begin
         @(posedge clk); #1;
         endAfter = endAdd;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int bad;
      exp_q.delete();
      subSel = 1'b0;
      fill_random();
      rst_n = 1'b0;
      startAdd = 1'b1;
      repeat (2) @(posedge clk); #1;
      checks++; if (endAdd !== 1'b0) begin failures++; $display("FAIL reset_endAdd got=%b want=0", endAdd); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
      push_zeros();
      bad = res_mismatches();
      checks++; if (bad !== 0) begin failures++; $display("FAIL reset_res bad_elems=%0d want=0", bad); end
      startAdd = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      checks++; if (endAdd !== 1'b0) begin failures++; $display("FAIL idle_endAdd got=%b want=0", endAdd); end
   endtask

   task automatic test_add_basic();
      int lat, bad;
      logic endAfter, early, eo;
      exp_q.delete();
      fill_const(16'h0100, 16'h0080);
      subSel = 1'b0;
      model_op(1'b0, eo);
      start_and_wait(lat, endAfter, early);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
      checks++; if (endAfter !== 1'b0) begin failures++; $display("FAIL basic_pulse_width endAdd_next=%b want=0", endAfter); end
      checks++; if (early !== 1'b0) begin failures++; $display("FAIL basic_res_hold early_change=%b want=0", early); end
      bad = res_mismatches();
      checks++; if (bad !== 0) begin failures++; $display("FAIL basic_res bad_elems=%0d want=0", bad); end
      checks++; if (ovf !== eo) begin failures++; $display("FAIL basic_ovf got=%b want=%b", ovf, eo); end
   endtask

   task automatic test_saturation();
      int lat, bad;
      logic endAfter, early, eo;
      exp_q.delete();
      fill_const(16'h7FF0, 16'h0020);
      subSel = 1'b0;
      model_op(1'b0, eo);
      start_and_wait(lat, endAfter, early);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL satpos_latency got=%0d want=%0d", lat, LAT); end
      bad = res_mismatches();
      checks++; if (bad !== 0) begin failures++; $display("FAIL satpos_res bad_elems=%0d want=0", bad); end
      checks++; if (ovf !== eo) begin failures++; $display("FAIL satpos_ovf got=%b want=%b", ovf, eo); end
      exp_q.delete();
      fill_const(16'h8010, 16'h0020);
      subSel = 1'b1;
      model_op(1'b1, eo);
      start_and_wait(lat, endAfter, early);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL satneg_latency got=%0d want=%0d", lat, LAT); end
      bad = res_mismatches();
      checks++; if (bad !== 0) begin failures++; $display("FAIL satneg_res bad_elems=%0d want=0", bad); end
      checks++; if (ovf !== eo) begin failures++; $display("FAIL satneg_ovf got=%b want=%b", ovf, eo); end
   endtask

   task automatic test_identity_sub();
      int lat, bad;
      logic endAfter, early, eo;
      exp_q.delete();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            A[r][c] = (r == c) ? W'(1) : W'(0);
            B[r][c] = W'(r*N + c);
         end
      subSel = 1'b1;
      model_op(1'b1, eo);
      start_and_wait(lat, endAfter, early);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL ident_latency got=%0d want=%0d", lat, LAT); end
      bad = res_mismatches();
      checks++; if (bad !== 0) begin failures++; $display("FAIL ident_res bad_elems=%0d want=0", bad); end
      checks++; if (ovf !== eo) begin failures++; $display("FAIL ident_ovf got=%b want=%b", ovf, eo); end
   endtask

   task automatic test_reset_mid_run();
      int lat, bad, pulses;
      logic endAfter, early, eo;
      exp_q.delete();
      do_reset();
      fill_random();
      subSel = 1'($urandom_range(0, 1));
      startAdd = 1'b1;
      @(posedge clk); #1;
      startAdd = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (endAdd === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_no_end pulses=%0d want=0", pulses); end
      push_zeros();
      bad = res_mismatches();
      checks++; if (bad !== 0) begin failures++; $display("FAIL abort_res_zero bad_elems=%0d want=0", bad); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL abort_ovf got=%b want=0", ovf); end
      model_op(subSel, eo);
      start_and_wait(lat, endAfter, early);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL restart_latency got=%0d want=%0d", lat, LAT); end
      bad = res_mismatches();
      checks++; if (bad !== 0) begin failures++; $display("FAIL restart_res bad_elems=%0d want=0", bad); end
      checks++; if (ovf !== eo) begin failures++; $display("FAIL restart_ovf got=%b want=%b", ovf, eo); end
   endtask

   task automatic test_operand_isolation();
      int pulses, firstAt, bad;
      logic eo, ovfGot;
      exp_q.delete();
      fill_random();
      subSel = 1'($urandom_range(0, 1));
      model_op(subSel, eo);
      pulses = 0; firstAt = -1; bad = -1; ovfGot = 1'bx;
      startAdd = 1'b1;
      @(posedge clk); #1;
      startAdd = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5) begin
            fill_random();
            subSel = ~subSel;
         end
         if (k == 8) startAdd = 1'b1;
         if (k == 9) startAdd = 1'b0;
         @(posedge clk); #1;
         if (endAdd === 1'b1) begin
            pulses++;
            if (firstAt < 0) begin
               firstAt = k;
               bad = res_mismatches();
               ovfGot = ovf;
            end
         end
      end
      checks++; if (pulses !== 1) begin failures++; $display("FAIL iso_single_end pulses=%0d want=1", pulses); end
      checks++; if (firstAt !== LAT) begin failures++; $display("FAIL iso_latency got=%0d want=%0d", firstAt, LAT); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL iso_res bad_elems=%0d want=0", bad); end
      checks++; if (ovfGot !== eo) begin failures++; $display("FAIL iso_ovf got=%b want=%b", ovfGot, eo); end
   endtask

   task automatic test_back_to_back();
      int pulseAt[$];
      int totalBad, ovfBad;
      logic eo;
      exp_q.delete();
      fill_random();
      subSel = 1'($urandom_range(0, 1));
      totalBad = 0; ovfBad = 0;
      startAdd = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (endAdd === 1'b1) begin
            pulseAt.push_back(k);
            model_op(subSel, eo);
            totalBad += res_mismatches();
            if (ovf !== eo) ovfBad++;
         end
      end
      startAdd = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      checks++; if (pulseAt.size() !== 3) begin failures++; $display("FAIL b2b_pulse_count got=%0d want=3", pulseAt.size()); end
      if (pulseAt.size() > 0) begin
         checks++; if (pulseAt[0] !== LAT) begin failures++; $display("FAIL b2b_first got=%0d want=%0d", pulseAt[0], LAT); end
      end
      for (int i = 1; i < pulseAt.size(); i++) begin
         checks++;
         if (pulseAt[i] - pulseAt[i-1] !== N*N + 3) begin
            failures++;
            $display("FAIL b2b_spacing idx=%0d got=%0d want=%0d", i, pulseAt[i] - pulseAt[i-1], N*N + 3);
         end
      end
      checks++; if (totalBad !== 0) begin failures++; $display("FAIL b2b_res bad_elems=%0d want=0", totalBad); end
      checks++; if (ovfBad !== 0) begin failures++; $display("FAIL b2b_ovf bad_ops=%0d want=0", ovfBad); end
   endtask

   task automatic test_random();
      int lat, bad;
      logic endAfter, early, eo;
      for (int t = 0; t < 8; t++) begin
         exp_q.delete();
         fill_random();
         subSel = 1'($urandom_range(0, 1));
         model_op(subSel, eo);
         start_and_wait(lat, endAfter, early);
         checks++; if (lat !== LAT) begin failures++; $display("FAIL rand%0d_latency got=%0d want=%0d", t, lat, LAT); end
         bad = res_mismatches();
         checks++; if (bad !== 0) begin failures++; $display("FAIL rand%0d_res bad_elems=%0d want=0", t, bad); end
         checks++; if (ovf !== eo) begin failures++; $display("FAIL rand%0d_ovf got=%b want=%b", t, ovf, eo); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      startAdd = 1'b0;
      subSel = 1'b0;
      fill_const('0, '0);
      test_reset();
      test_add_basic();
      test_saturation();
      test_identity_sub();
      test_reset_mid_run();
      test_operand_isolation();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matrix_add_sat.md
MATRIX_ADD_SAT -- requirements
Module: matrix_add_sat

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, element width in bits (signed two's-complement fixed point).
REQ-002 The block SHALL expose parameter nos, default 4, matrix dimension (nos x nos).
REQ-003 The block SHALL expose parameter intDigits, default 16, integer-bit count of the fixed-point format (passed through only; add/sub is format-agnostic).
REQ-004 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port: startAdd  input  1  start request, sampled in IDLE only.
REQ-007 Port: subSel  input  1  operation select (0: Res = A + B; 1: Res = A - B), sampled with startAdd.
REQ-008 Port: A  input  WIDTH x [nos][nos]  left operand (typically the product output of the upstream triple-product stage).
REQ-009 Port: B  input  WIDTH x [nos][nos]  right operand (e.g. process-noise matrix Q).
REQ-010 Port: Res  output  WIDTH x [nos][nos]  registered result matrix.
REQ-011 Port: endAdd  output  1  completion pulse, high for exactly one cycle.
REQ-012 Port: ovf  output  1  saturation flag for the last completed operation.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, RUN, DONE; any other encoding SHALL return to IDLE.
REQ-014 IDLE -> LOAD when startAdd=1; otherwise remain in IDLE.
REQ-015 In LOAD (one cycle) A, B and subSel SHALL be captured into internal operand registers, element index cleared to 0, sticky overflow cleared; LOAD -> RUN.
REQ-016 In RUN one element per cycle SHALL be computed in row-major order (index = row*nos + col) into an internal working matrix; RUN -> DONE after index nos*nos-1 is processed.
REQ-017 Each element SHALL be computed at WIDTH+1 bits and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any saturation SHALL set the sticky overflow bit.
REQ-018 In DONE the working matrix SHALL be copied to Res, ovf updated from the sticky bit, endAdd=1; DONE -> IDLE unconditionally.
REQ-019 Res and ovf SHALL change only on the DONE cycle and hold otherwise.
REQ-020 Latency: startAdd sampled at edge 0 -> endAdd high during the cycle following edge nos*nos+2 (18 cycles for nos=4).
REQ-021 startAdd outside IDLE SHALL be ignored; startAdd high in DONE SHALL NOT start a new operation until IDLE is re-entered.
REQ-022 Changes on A, B or subSel after LOAD SHALL NOT affect the running operation.
REQ-023 startAdd held high continuously SHALL cause back-to-back operations with one IDLE cycle between them.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, Res all zeros, endAdd=0, ovf=0, index 0, working and operand registers zero.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no endAdd and no Res update; after release the block SHALL wait in IDLE for startAdd.

Structure
REQ-026 The FSM state enum and a saturating add/sub function SHALL live in the shared kalman_pkg package, reused by other element-wise stages.
REQ-027 The per-element saturating adder SHALL be one sub-module, sat_add_sub (inputs a, b, sub; outputs y, sat), instantiated once.

Verification (WIDTH=16, nos=4)
REQ-028 A=all 0x0100, B=all 0x0080, subSel=0, start -> endAdd at cycle 18, Res=all 0x0180, ovf=0.
REQ-029 A=all 0x7FF0, B=all 0x0020, subSel=0 -> Res=all 0x7FFF, ovf=1; A=all 0x8010, B=all 0x0020, subSel=1 -> Res=all 0x8000, ovf=1.
REQ-030 Identity A, B[i][j]=i*4+j, subSel=1 -> Res[i][j]=A[i][j]-B[i][j] per element, row-major check, ovf=0.
REQ-031 rst_n pulsed low at cycle 8 of RUN -> no endAdd, Res stays 0; new start after release -> correct result at cycle 18.
REQ-032 Change A and B at cycle 5 after start, pulse startAdd during RUN -> Res reflects operands captured in LOAD, single endAdd only.
REQ-033 startAdd held high for 60 cycles -> endAdd pulses spaced 19 cycles apart, each Res correct.
